rename_ckpt_ctrl: RTL and testbench
===================================

Name: rename_ckpt_ctrl

Overview:
- Sequences branch checkpoint/recovery of the rename stage (map table snapshots + free-list read pointer).
- Sits beside the rename block. Hands out a checkpoint tag whenever rename fires a branch, and snapshots the free-list read pointer for that tag.
- On branch resolve it frees the checkpoint (correct prediction) or drives a timed restore/flush sequence (mispredict), stalling rename for the duration.
- Map-table snapshot storage lives in the map table; this block only issues tagged save/restore commands.

Parameters:
- NUM_CKPT, 4, number of checkpoints; power of two.
- CKPT_W, $clog2(NUM_CKPT), tag width.
- FL_PTR_W, 7, free-list read-pointer width (96-entry free list: P32..P127).
- RESTORE_CYCLES, 2, cycles rename stays stalled after the restore pulse (DRAIN length); ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- alloc_req  in  1  rename is firing a branch this cycle
- alloc_ready  out  1  checkpoint available and controller IDLE
- alloc_tag  out  CKPT_W  tag granted; valid when alloc_req && alloc_ready
- fl_rd_ptr  in  FL_PTR_W  current free-list read pointer, snapshotted on alloc
- save_valid  out  1  map table must snapshot into save_tag (same cycle as alloc fire)
- save_tag  out  CKPT_W  equals alloc_tag
- resolve_valid  in  1  branch resolution
- resolve_tag  in  CKPT_W  checkpoint being resolved
- resolve_mispredict  in  1  1 = mispredict, 0 = correct
- restore_valid  out  1  one-cycle restore command
- restore_tag  out  CKPT_W  map-table snapshot to restore
- restore_fl_ptr  out  FL_PTR_W  free-list read pointer to restore
- flush  out  1  one-cycle pipeline flush, coincident with restore_valid
- rename_stall  out  1  rename must not fire
- ckpt_count  out  CKPT_W+1  live checkpoints

Behaviour:
- Storage: circular buffer of NUM_CKPT entries {valid, resolved, fl_ptr}; head (oldest) and tail (next alloc) pointers, each CKPT_W+1 bits with a wrap bit.
  - count = tail − head.
  - full = count == NUM_CKPT.
- Reset: head = tail = 0, all valid/resolved = 0, state IDLE. All outputs 0 except alloc_ready = 1 and alloc_tag = 0.
- Allocation:
  - alloc_tag = tail[CKPT_W-1:0].
  - alloc_ready = state==IDLE && !full && !(resolve_valid && resolve_mispredict && tag live).
  - On fire: entry[tail] = {1, 0, fl_rd_ptr}; tail++. save_valid/save_tag asserted combinationally in the same cycle.
- Live tag: entry valid && (tag − head) mod NUM_CKPT < count. Resolves on non-live tags are ignored.
- Correct resolve: mark resolved.
  - Every cycle, head advances by one while entry[head] is valid && resolved; that entry's valid is cleared. Retirement is in order, one per cycle.
  - Out-of-order resolves are allowed.
- Mispredict on live tag t:
  - Next cycle: restore_valid = flush = 1, restore_tag = t, restore_fl_ptr = entry[t].fl_ptr.
  - tail = head-relative position of t, so t and all younger entries are invalidated. state → RESTORE.
- FSM:
  - IDLE → RESTORE on an accepted mispredict.
  - RESTORE (1 cycle, restore pulse) → DRAIN.
  - DRAIN counts RESTORE_CYCLES cycles → IDLE.
  - rename_stall = state != IDLE.
- Mispredicts during RESTORE/DRAIN:
  - A live tag older than the one being restored re-enters RESTORE with the new tag and the drain counter reset.
  - Equal or younger tags are ignored, since they were already squashed.
  - Correct resolves continue to be accepted in every state.
- Simultaneous events:
  - Mispredict and alloc in the same cycle: the mispredict wins and alloc_ready is low.
  - Correct resolve and alloc in the same cycle: both take effect.
  - Head retire and mispredict in the same cycle: the retire takes effect first if its tag ≠ t.
- Full: alloc_ready = 0; rename holds the branch.
- Empty: mispredict is ignored because no tag is live.
- Wrap-around: pointer arithmetic is modulo 2·NUM_CKPT, which distinguishes full from empty.
- Reset mid-RESTORE/DRAIN: asynchronous return to the reset state; no restore pulse is emitted.

Decomposition:
- Shared rename package holds:
  - NUM_PREGS = 128, NUM_AREGS = 32, START_PREG = 32
  - ckpt_tag_t and fl_ptr_t typedefs
  - ckpt_entry_t struct {valid, resolved, fl_ptr}
  - recovery state enum {IDLE, RESTORE, DRAIN}
- Natural sub-module: rename_ckpt_age_cmp, the combinational "tag a older than tag b relative to head" comparator. It is used by both the liveness check and the mispredict-priority check.

Test Plan:
1. After reset, alloc_req with fl_rd_ptr = 5 → alloc_tag = 0, save_valid = 1, ckpt_count = 1. A second alloc with ptr = 9 → tag 1, count 2.
2. Allocate 4 checkpoints → alloc_ready = 0 and count = 4. Resolve tag 0 correct → next cycle count = 3, alloc_ready = 1. A 5th alloc gets tag 0 (wrap).
3. Checkpoints 0..3 with ptrs 10/20/30/40; mispredict tag 1 → next cycle restore_valid = flush = 1, restore_tag = 1, restore_fl_ptr = 20, count = 1. rename_stall high for 1 + 2 cycles, then IDLE; next alloc_tag = 1.
4. Resolve tag 2 correct, then tag 0 correct → head advances 0 → 1 → stops at 1. Resolve tag 1 correct → head reaches 3 and count = 1.
5. Mispredict tag 2, then during DRAIN mispredict tag 0 → second restore pulse with tag 0 and the drain restarts. A mispredict on tag 3 during DRAIN → ignored.
6. Assert rst mid-DRAIN → immediately count = 0, rename_stall = 0, alloc_ready = 1, no restore pulse.

Source files
------------

// File: rtl/rename_ckpt_ctrl_pkg.sv
// Shared rename-stage definitions: register-file geometry, checkpoint
// tag / free-list pointer types, checkpoint entry layout and the
// recovery sequencer state encoding.
package rename_ckpt_ctrl_pkg;

   localparam int unsigned NUM_PREGS    = 128;
   localparam int unsigned NUM_AREGS    = 32;
   // Physical registers below START_PREG hold the initial architectural map.
   localparam int unsigned START_PREG   = NUM_AREGS;

   localparam int unsigned NUM_CKPT_DEF = 4;
   localparam int unsigned CKPT_W_DEF   = $clog2(NUM_CKPT_DEF);
   // Free list covers P32..P127 (96 entries).
   localparam int unsigned FL_PTR_W_DEF = $clog2(NUM_PREGS - START_PREG);

   typedef logic [CKPT_W_DEF-1:0]   ckpt_tag_t;
   typedef logic [FL_PTR_W_DEF-1:0] fl_ptr_t;

   typedef struct packed {
      logic    valid;
      logic    resolved;
      fl_ptr_t fl_ptr;
   } ckpt_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      RESTORE,
      DRAIN
   } rcv_state_t;

endpackage

// File: rtl/rename_ckpt_age_cmp.sv
// Combinational checkpoint age comparator.
//   head    : tag of the oldest live checkpoint
//   a, b    : tags to compare
//   a_older : a sits strictly closer to head than b (modulo the ring size)
module rename_ckpt_age_cmp #(
   parameter int unsigned CKPT_W = 2
) (
   input  logic [CKPT_W-1:0] head,
   input  logic [CKPT_W-1:0] a,
   input  logic [CKPT_W-1:0] b,
   output logic              a_older
);

   logic [CKPT_W-1:0] rel_a;
   logic [CKPT_W-1:0] rel_b;

   always_comb begin
      rel_a   = a - head;
      rel_b   = b - head;
      a_older = rel_a < rel_b;
   end

endmodule

// File: rtl/rename_ckpt_ctrl.sv
// Branch checkpoint controller for the rename stage.
// Hands out checkpoint tags as rename fires branches, keeps the free-list
// read pointer per checkpoint, retires correctly predicted checkpoints in
// order and sequences restore/flush/stall on a mispredict.
// Ports:
//   clk, rst                    clock, async active-high reset
//   alloc_req/ready/tag         checkpoint allocation handshake
//   fl_rd_ptr                   free-list read pointer captured on alloc
//   save_valid/save_tag         map-table snapshot command (same cycle as alloc)
//   resolve_valid/tag/mispredict branch resolution
//   restore_valid/tag/fl_ptr    one-cycle map-table / free-list restore command
//   flush                       pipeline flush, coincident with restore_valid
//   rename_stall                rename must not fire
//   ckpt_count                  number of live checkpoints
module rename_ckpt_ctrl
   import rename_ckpt_ctrl_pkg::*;
#(
   parameter int unsigned NUM_CKPT       = NUM_CKPT_DEF,
   parameter int unsigned CKPT_W         = $clog2(NUM_CKPT),
   parameter int unsigned FL_PTR_W       = FL_PTR_W_DEF,
   parameter int unsigned RESTORE_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                alloc_req,
   output logic                alloc_ready,
   output logic [CKPT_W-1:0]   alloc_tag,
   input  logic [FL_PTR_W-1:0] fl_rd_ptr,
   output logic                save_valid,
   output logic [CKPT_W-1:0]   save_tag,
   input  logic                resolve_valid,
   input  logic [CKPT_W-1:0]   resolve_tag,
   input  logic                resolve_mispredict,
   output logic                restore_valid,
   output logic [CKPT_W-1:0]   restore_tag,
   output logic [FL_PTR_W-1:0] restore_fl_ptr,
   output logic                flush,
   output logic                rename_stall,
   output logic [CKPT_W:0]     ckpt_count
);

   localparam int unsigned       DRAIN_W    = (RESTORE_CYCLES > 1) ? $clog2(RESTORE_CYCLES) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RESTORE_CYCLES - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
   localparam logic [CKPT_W:0]    PTR_ONE    = (CKPT_W+1)'(1);
   localparam logic [CKPT_W:0]    PTR_FULL   = (CKPT_W+1)'(NUM_CKPT);

   rcv_state_t            state_q, state_d;
   logic [DRAIN_W-1:0]    drain_q, drain_d;
   logic [CKPT_W:0]       head_q, tail_q, head_d, tail_d, count;
   logic [NUM_CKPT-1:0]   valid_q, resolved_q, squash;
   logic [FL_PTR_W-1:0]   fl_q [NUM_CKPT];
   logic [CKPT_W-1:0]     cur_tag_q;
   logic [FL_PTR_W-1:0]   cur_fl_q;
   logic [CKPT_W-1:0]     head_lo, tail_lo, mp_pos, rel;
   logic                  full, in_range, older_than_cur, tag_live;
   logic                  mp_req, mp_accept, cr_accept, alloc_fire, retire;

   assign count   = tail_q - head_q;
   assign full    = (count == PTR_FULL);
   assign head_lo = head_q[CKPT_W-1:0];
   assign tail_lo = tail_q[CKPT_W-1:0];

   // Liveness: resolve_tag lies between head and tail.
   rename_ckpt_age_cmp #(.CKPT_W(CKPT_W)) u_live_cmp (
      .head    (head_lo),
      .a       (resolve_tag),
      .b       (tail_lo),
      .a_older (in_range)
   );

   // Priority: a mispredict during recovery must be older than the one in flight.
   rename_ckpt_age_cmp #(.CKPT_W(CKPT_W)) u_prio_cmp (
      .head    (head_lo),
      .a       (resolve_tag),
      .b       (cur_tag_q),
      .a_older (older_than_cur)
   );

   assign tag_live   = valid_q[resolve_tag] && (full || in_range);
   assign mp_req     = resolve_valid && resolve_mispredict && tag_live;
   assign mp_accept  = mp_req && ((state_q == IDLE) || older_than_cur);
   assign cr_accept  = resolve_valid && !resolve_mispredict && tag_live;

   assign alloc_ready = (state_q == IDLE) && !full && !mp_req;
   assign alloc_fire  = alloc_req && alloc_ready;
   assign alloc_tag   = tail_lo;
   assign save_valid  = alloc_fire;
   assign save_tag    = tail_lo;

   // A correct resolve on the head retires it in the same cycle; a mispredict
   // on the head tag blocks its retirement so the restore sees it.
   assign retire = valid_q[head_lo]
                && (resolved_q[head_lo] || (cr_accept && (resolve_tag == head_lo)))
                && !(mp_accept && (resolve_tag == head_lo));

   assign mp_pos = resolve_tag - head_lo;

   always_comb begin
      squash = '0;
      rel    = '0;
      for (int unsigned i = 0; i < NUM_CKPT; i++) begin
         rel       = CKPT_W'(i) - head_lo;
         squash[i] = mp_accept && (rel >= mp_pos);
      end
   end

   always_comb begin
      head_d = retire ? (head_q + PTR_ONE) : head_q;
      tail_d = tail_q;
      if (mp_accept) begin
         tail_d = head_q + {1'b0, mp_pos};
      end else if (alloc_fire) begin
         tail_d = tail_q + PTR_ONE;
      end
   end

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      case (state_q)
         IDLE: begin
            if (mp_accept) state_d = RESTORE;
         end
         RESTORE: begin
            drain_d = '0;
            state_d = mp_accept ? RESTORE : DRAIN;
         end
         DRAIN: begin
            if (mp_accept) begin
               state_d = RESTORE;
            end else if (drain_q == DRAIN_LAST) begin
               state_d = IDLE;
            end else begin
               drain_d = drain_q + DRAIN_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         drain_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         valid_q    <= '0;
         resolved_q <= '0;
         cur_tag_q  <= '0;
         cur_fl_q   <= '0;
         for (int unsigned i = 0; i < NUM_CKPT; i++) begin
            fl_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         if (mp_accept) begin
            cur_tag_q <= resolve_tag;
            cur_fl_q  <= fl_q[resolve_tag];
         end
         for (int unsigned i = 0; i < NUM_CKPT; i++) begin
            if (cr_accept && (resolve_tag == CKPT_W'(i))) begin
               resolved_q[i] <= 1'b1;
            end
            if ((retire && (head_lo == CKPT_W'(i))) || squash[i]) begin
               valid_q[i]    <= 1'b0;
               resolved_q[i] <= 1'b0;
            end
            if (alloc_fire && (tail_lo == CKPT_W'(i))) begin
               valid_q[i]    <= 1'b1;
               resolved_q[i] <= 1'b0;
               fl_q[i]       <= fl_rd_ptr;
            end
         end
      end
   end

   assign restore_valid  = (state_q == RESTORE);
   assign flush          = (state_q == RESTORE);
   assign restore_tag    = cur_tag_q;
   assign restore_fl_ptr = cur_fl_q;
   assign rename_stall   = (state_q != IDLE);
   assign ckpt_count     = count;

endmodule

// File: tb/tb_rename_ckpt_ctrl.sv
// Self-checking bench for rename_ckpt_ctrl: directed scenarios followed by a
// random phase, all checked against an age-ordered queue model of the
// checkpoints.
module tb_rename_ckpt_ctrl;

   localparam int NC = 4;
   localparam int RC = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       alloc_req;
   logic       alloc_ready;
   logic [1:0] alloc_tag;
   logic [6:0] fl_rd_ptr;
   logic       save_valid;
   logic [1:0] save_tag;
   logic       resolve_valid;
   logic [1:0] resolve_tag;
   logic       resolve_mispredict;
   logic       restore_valid;
   logic [1:0] restore_tag;
   logic [6:0] restore_fl_ptr;
   logic       flush;
   logic       rename_stall;
   logic [2:0] ckpt_count;

   always #5 clk = ~clk;

   rename_ckpt_ctrl #(
      .NUM_CKPT       (NC),
      .FL_PTR_W       (7),
      .RESTORE_CYCLES (RC)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .alloc_req          (alloc_req),
      .alloc_ready        (alloc_ready),
      .alloc_tag          (alloc_tag),
      .fl_rd_ptr          (fl_rd_ptr),
      .save_valid         (save_valid),
      .save_tag           (save_tag),
      .resolve_valid      (resolve_valid),
      .resolve_tag        (resolve_tag),
      .resolve_mispredict (resolve_mispredict),
      .restore_valid      (restore_valid),
      .restore_tag        (restore_tag),
      .restore_fl_ptr     (restore_fl_ptr),
      .flush              (flush),
      .rename_stall       (rename_stall),
      .ckpt_count         (ckpt_count)
   );

   // Reference model: live checkpoints oldest-first; m_stall counts the
   // remaining stalled cycles (RC+1 means the restore pulse is due now).
   typedef struct {
      int tag;
      int ptr;
      bit res;
   } ment_t;

   ment_t mq[$];
   int    m_tail, m_stall, m_ptag, m_pptr;
   int    total = 0;
   int    bad   = 0;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
      end
   endtask

   function automatic int find(input int t);
      for (int i = 0; i < mq.size(); i++) begin
         if (mq[i].tag == t) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_tail  = 0;
      m_stall = 0;
      m_ptag  = 0;
      m_pptr  = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      alloc_req = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0;
      #1;
      model_reset();
      chk("rst_count",   32'(ckpt_count),    0);
      chk("rst_stall",   32'(rename_stall),  0);
      chk("rst_ready",   32'(alloc_ready),   1);
      chk("rst_tag",     32'(alloc_tag),     0);
      chk("rst_restore", 32'(restore_valid), 0);
      chk("rst_flush",   32'(flush),         0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   // One clock cycle: drive inputs, check every output against the model,
   // advance the model, then let the DUT take the edge.
   task automatic cyc(input bit a, input int p, input bit rv, input int rt, input bit rm);
      int idx;
      bit mp_hit, ready_e, fire, pulse;
      ment_t e;
      alloc_req = a; fl_rd_ptr = 7'(p);
      resolve_valid = rv; resolve_tag = 2'(rt); resolve_mispredict = rm;
      #1;
      idx     = find(rt);
      mp_hit  = rv && rm && (idx >= 0);
      ready_e = (m_stall == 0) && (mq.size() < NC) && !mp_hit;
      fire    = a && ready_e;
      pulse   = (m_stall == RC + 1);
      chk("alloc_ready",   32'(alloc_ready),   32'(ready_e));
      chk("alloc_tag",     32'(alloc_tag),     m_tail);
      chk("save_valid",    32'(save_valid),    32'(fire));
      if (fire) chk("save_tag", 32'(save_tag), m_tail);
      chk("ckpt_count",    32'(ckpt_count),    mq.size());
      chk("rename_stall",  32'(rename_stall),  32'(m_stall > 0));
      chk("restore_valid", 32'(restore_valid), 32'(pulse));
      chk("flush",         32'(flush),         32'(pulse));
      if (pulse) begin
         chk("restore_tag",    32'(restore_tag),    m_ptag);
         chk("restore_fl_ptr", 32'(restore_fl_ptr), m_pptr);
      end
      if (rv && !rm && idx >= 0) mq[idx].res = 1'b1;
      if (mq.size() > 0 && mq[0].res && !(mp_hit && mq[0].tag == rt)) void'(mq.pop_front());
      if (mp_hit) begin
         idx    = find(rt);
         m_ptag = rt;
         m_pptr = mq[idx].ptr;
         while (mq.size() > idx) void'(mq.pop_back());
         m_tail  = rt;
         m_stall = RC + 1;
      end else if (m_stall > 0) begin
         m_stall--;
      end
      if (fire) begin
         e.tag = m_tail; e.ptr = p; e.res = 1'b0;
         mq.push_back(e);
         m_tail = (m_tail + 1) % NC;
      end
      @(negedge clk);
      alloc_req = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      alloc_req = 1'b0; fl_rd_ptr = '0;
      resolve_valid = 1'b0; resolve_tag = '0; resolve_mispredict = 1'b0;

      // 1: first allocations
      do_reset();
      cyc(1, 5, 0, 0, 0);
      chk("t1_count1", 32'(ckpt_count), 1);
      cyc(1, 9, 0, 0, 0);
      chk("t1_count2", 32'(ckpt_count), 2);

      // 2: full, retire, wrap
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, 10 * (i + 1), 0, 0, 0);
      chk("t2_full_ready", 32'(alloc_ready), 0);
      chk("t2_full_count", 32'(ckpt_count),  4);
      cyc(0, 0, 1, 0, 0);
      chk("t2_count3", 32'(ckpt_count),  3);
      chk("t2_ready",  32'(alloc_ready), 1);
      chk("t2_wrap",   32'(alloc_tag),   0);
      cyc(1, 50, 0, 0, 0);

      // 3: mispredict, restore pulse, stall length
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, 10 * (i + 1), 0, 0, 0);
      cyc(0, 0, 1, 1, 1);
      chk("t3_rv",    32'(restore_valid),  1);
      chk("t3_flush", 32'(flush),          1);
      chk("t3_tag",   32'(restore_tag),    1);
      chk("t3_ptr",   32'(restore_fl_ptr), 20);
      chk("t3_count", 32'(ckpt_count),    1);
      cyc(0, 0, 0, 0, 0);
      chk("t3_stall_d0", 32'(rename_stall), 1);
      cyc(0, 0, 0, 0, 0);
      chk("t3_stall_d1", 32'(rename_stall), 1);
      cyc(0, 0, 0, 0, 0);
      chk("t3_idle",    32'(rename_stall), 0);
      chk("t3_nexttag", 32'(alloc_tag),    1);
      cyc(1, 60, 0, 0, 0);

      // 4: out-of-order resolves, in-order retirement
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, 10 * (i + 1), 0, 0, 0);
      cyc(0, 0, 1, 2, 0);
      chk("t4_no_retire", 32'(ckpt_count), 4);
      cyc(0, 0, 1, 0, 0);
      chk("t4_head1", 32'(ckpt_count), 3);
      cyc(0, 0, 0, 0, 0);
      chk("t4_stop1", 32'(ckpt_count), 3);
      cyc(0, 0, 1, 1, 0);
      cyc(0, 0, 0, 0, 0);
      chk("t4_head3", 32'(ckpt_count), 1);

      // 5: older mispredict during drain re-enters restore; younger ignored
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, 10 * (i + 1), 0, 0, 0);
      cyc(0, 0, 1, 2, 1);
      chk("t5_tag2", 32'(restore_tag), 2);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 1);
      chk("t5_rv2",   32'(restore_valid),  1);
      chk("t5_tag0",  32'(restore_tag),    0);
      chk("t5_ptr0",  32'(restore_fl_ptr), 10);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 3, 1);
      chk("t5_ignored", 32'(restore_valid), 0);
      cyc(0, 0, 0, 0, 0);
      chk("t5_idle", 32'(rename_stall), 0);

      // 6: reset during drain
      do_reset();
      cyc(1, 7, 0, 0, 0);
      cyc(1, 8, 0, 0, 0);
      cyc(0, 0, 1, 0, 1);
      cyc(0, 0, 0, 0, 0);
      chk("t6_in_drain", 32'(rename_stall), 1);
      do_reset();
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      // Random phase
      for (int n = 0; n < 400; n++) begin
         cyc(bit'($urandom_range(0, 9) < 7), int'($urandom_range(0, 127)),
             bit'($urandom_range(0, 9) < 5), int'($urandom_range(0, 3)),
             bit'($urandom_range(0, 9) < 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
